hyperbus_trx_sched: RTL and testbench
=====================================

# hyperbus_trx_sched

Transaction scheduler between the AXI front end and the HyperBus PHY. Arbitrates round-robin between one read and one write request channel and issues one transaction at a time to the PHY. Optionally splits long bursts into bounded chunks so CS# low time stays within tCSM. Enforces a configurable CS#-high recovery gap (tRWR) between consecutive PHY transactions.

## Interface
Parameters:
- `NumChips`, 2: number of chip selects; chip index width `CsW = max(1, $clog2(NumChips))`.
- `AddrWidth`, 32: word address width; a word is 16 bits.
- `LenWidth`, 16: burst length width, encoded as words-1.
- `MaxBurst`, 64: maximum words per PHY transaction when splitting is enabled; must be ≥1.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `rd_valid_i` in 1: read request valid.
- `rd_ready_o` out 1: read request accepted (one-cycle pulse).
- `rd_addr_i` in AddrWidth: read start word address.
- `rd_len_i` in LenWidth: read length, words-1.
- `rd_cs_i` in CsW: read target chip index.
- `wr_valid_i`, `wr_ready_o`, `wr_addr_i`, `wr_len_i`, `wr_cs_i`: same as the read channel, for writes.
- `trx_valid_o` out 1: PHY transaction valid.
- `trx_ready_i` in 1: PHY accepts transaction.
- `trx_write_o` out 1: 1 = write, 0 = read.
- `trx_addr_o` out AddrWidth: chunk start word address.
- `trx_len_o` out LenWidth: chunk length, words-1.
- `trx_cs_o` out NumChips: one-hot chip select.
- `trx_last_o` out 1: final chunk of the parent request.
- `phy_done_i` in 1: one-cycle pulse when the PHY has finished and released CS#.
- `cfg_rwr_i` in 8: recovery cycles after each `phy_done_i`.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RECOVER.
- IDLE, arbitration:
  - If exactly one of `rd_valid_i` / `wr_valid_i` is high, grant that channel.
  - If both are high, grant the channel not granted last. The priority pointer resets to favour read.
  - On grant: pulse the granted `*_ready_o`, latch addr/len/cs/dir, update the pointer, go to ISSUE.
  - Requesters hold payload stable while valid and not ready.
- ISSUE:
  - Drive `trx_valid_o` with the current chunk.
  - Chunk words = min(remaining, MaxBurst); `trx_len_o` = words-1.
  - `trx_last_o` = 1 when remaining ≤ MaxBurst.
  - Payload is stable while `trx_valid_o && !trx_ready_i`.
  - On handshake: go to WAIT_DONE, addr += words, remaining -= words.
- WAIT_DONE: wait for `phy_done_i`, then load the recovery counter with `cfg_rwr_i`.
  - If `cfg_rwr_i` = 0: go to ISSUE if words remain, else IDLE.
  - Otherwise go to RECOVER.
- RECOVER: count down `cfg_rwr_i` cycles. At expiry go to ISSUE if words remain, else IDLE.
- `phy_done_i` outside WAIT_DONE is ignored.
- A change of `cfg_rwr_i` takes effect at the next load.
- Address arithmetic wraps modulo 2^AddrWidth; no chip-boundary handling is performed.
- Remaining count is LenWidth+1 bits wide, so a full-length request (len = all ones) is handled.

## Timing
- Reset values: all `*_ready_o`, `trx_valid_o`, `trx_write_o`, `trx_addr_o`, `trx_len_o`, `trx_cs_o`, `trx_last_o`, `busy_o` = 0. State = IDLE, pointer = read.
- All outputs are registered except `*_ready_o`, which is a combinational grant gated by state IDLE.
- Grant in cycle N → `trx_valid_o` high in cycle N+1.
- `phy_done_i` in cycle M:
  - With `cfg_rwr_i` = k > 0: next `trx_valid_o` or IDLE at M+1+k.
  - With `cfg_rwr_i` = 0: next `trx_valid_o` or IDLE at M+1.
- Earliest next grant is the cycle state returns to IDLE; no new request is accepted while busy.
- Reset asserted mid-operation: immediate return to reset values. The in-flight parent request is dropped and the requester must reissue it. The PHY is reset alongside.

## Configuration
- `HYPERBUS_BURST_SPLIT_EN` defined: splitting by `MaxBurst` as described above.
- `HYPERBUS_BURST_SPLIT_EN` undefined:
  - Every parent request is issued as a single chunk: `trx_len_o` = request len, `trx_last_o` = 1.
  - `MaxBurst` is unused; the remaining/address update logic is not built.

## Test plan
- Read only, addr 0x40, len 3, cs 1, `cfg_rwr_i` = 4:
  - `rd_ready_o` pulses.
  - Next cycle: `trx_valid_o` with write = 0, addr 0x40, len 3, cs = 2'b10, last = 1.
  - After `phy_done_i`: `busy_o` stays high exactly 4 more cycles.
- `rd_valid_i` and `wr_valid_i` both high from reset, `phy_done_i` two cycles after each handshake:
  - Read granted first, then write, then read.
  - Strict alternation holds while both remain valid.
- Split enabled, `MaxBurst` = 64, write addr 0x100, len 149, `cfg_rwr_i` = 2:
  - Three chunks: (0x100, 63, last 0), (0x140, 63, last 0), (0x180, 21, last 1).
  - Each chunk issued 3 cycles after the preceding `phy_done_i`.
  - With the macro undefined: a single chunk (0x100, 149, last 1).
- `trx_ready_i` held low 10 cycles: `trx_valid_o` and the whole payload stay constant; one handshake occurs on release.
- `cfg_rwr_i` = 0, len 0: `phy_done_i` in cycle M → `busy_o` = 0 and a new grant is possible in cycle M+1.
- `rst_i` pulsed during WAIT_DONE of a split write:
  - All outputs are 0 in the same cycle.
  - After release, a new read is served normally and no stale chunk is issued.

Source files
------------

// File: rtl/hyperbus_trx_sched.sv
// hyperbus_trx_sched: round-robin scheduler between one read and one write
// request channel, issuing one HyperBus PHY transaction at a time and
// holding CS# high for a programmable recovery time after each one.
// Optional feature macro: HYPERBUS_BURST_SPLIT_EN. When it is defined, long
// requests are cut into chunks of at most MaxBurst words. When it is not
// defined, every request goes out as a single chunk.
module hyperbus_trx_sched #(
    parameter int NumChips  = 2,
    parameter int AddrWidth = 32,
    parameter int LenWidth  = 16,
    parameter int MaxBurst  = 64,
    localparam int CsW      = (NumChips > 1) ? $clog2(NumChips) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_valid_i,
    output logic                 rd_ready_o,
    input  logic [AddrWidth-1:0] rd_addr_i,
    input  logic [LenWidth-1:0]  rd_len_i,
    input  logic [CsW-1:0]       rd_cs_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [LenWidth-1:0]  wr_len_i,
    input  logic [CsW-1:0]       wr_cs_i,
    output logic                 trx_valid_o,
    input  logic                 trx_ready_i,
    output logic                 trx_write_o,
    output logic [AddrWidth-1:0] trx_addr_o,
    output logic [LenWidth-1:0]  trx_len_o,
    output logic [NumChips-1:0]  trx_cs_o,
    output logic                 trx_last_o,
    input  logic                 phy_done_i,
    input  logic [7:0]           cfg_rwr_i,
    output logic                 busy_o
);

    localparam int RemW = LenWidth + 1;

    if (MaxBurst < 1) begin : g_maxburst_check
        $error("hyperbus_trx_sched: MaxBurst must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RECOVER} state_t;

    state_t                state_q, state_d;
    logic                  ptr_wr_q;
    logic [7:0]            rwr_cnt_q;
    logic                  in_idle;
    logic                  grant_rd, grant_wr, grant_any;
    logic                  handshake;
    logic                  more_left;
    logic [AddrWidth-1:0]  req_addr;
    logic [LenWidth-1:0]   req_len;
    logic [CsW-1:0]        req_cs;
    logic [AddrWidth-1:0]  src_addr;
    logic [LenWidth-1:0]   chunk_len;
    logic                  chunk_last;

    // The grant is combinational so a request is accepted in the cycle it is
    // seen in IDLE. When both channels request, ptr_wr_q picks the one that
    // lost last time.
    assign in_idle    = (state_q == IDLE) && !rst_i;
    assign grant_rd   = in_idle && rd_valid_i && (!wr_valid_i || !ptr_wr_q);
    assign grant_wr   = in_idle && wr_valid_i && (!rd_valid_i || ptr_wr_q);
    assign grant_any  = grant_rd || grant_wr;
    assign rd_ready_o = grant_rd;
    assign wr_ready_o = grant_wr;
    assign handshake  = trx_valid_o && trx_ready_i;

    assign req_addr = grant_wr ? wr_addr_i : rd_addr_i;
    assign req_len  = grant_wr ? wr_len_i  : rd_len_i;
    assign req_cs   = grant_wr ? wr_cs_i   : rd_cs_i;

`ifdef HYPERBUS_BURST_SPLIT_EN
    localparam logic [RemW-1:0] MaxBurstW = RemW'(MaxBurst);

    logic [AddrWidth-1:0] addr_q;
    logic [RemW-1:0]      rem_q;
    logic [RemW-1:0]      src_rem;
    logic [RemW-1:0]      chunk_words;
    logic [RemW-1:0]      hs_words;

    // A fresh request starts from the requester's payload. A follow-on chunk
    // starts from the address and word count left over by the previous chunk.
    assign src_addr    = (state_q == IDLE) ? req_addr : addr_q;
    assign src_rem     = (state_q == IDLE) ? ({1'b0, req_len} + RemW'(1)) : rem_q;
    assign chunk_words = (src_rem > MaxBurstW) ? MaxBurstW : src_rem;
    assign chunk_len   = LenWidth'(chunk_words - RemW'(1));
    assign chunk_last  = (src_rem <= MaxBurstW);
    assign hs_words    = {1'b0, trx_len_o} + RemW'(1);
    assign more_left   = (rem_q != '0);

    // Track the address and word count still owed to the parent request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else if (grant_any) begin
            addr_q <= req_addr;
            rem_q  <= {1'b0, req_len} + RemW'(1);
        end else if (handshake) begin
            addr_q <= addr_q + AddrWidth'(hs_words);
            rem_q  <= rem_q - hs_words;
        end
    end
`else
    assign src_addr   = req_addr;
    assign chunk_len  = req_len;
    assign chunk_last = 1'b1;
    assign more_left  = 1'b0;
`endif

    // State register plus round-robin pointer (reset favours read).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_rd) begin
                ptr_wr_q <= 1'b1;
            end else if (grant_wr) begin
                ptr_wr_q <= 1'b0;
            end
        end
    end

    // Next-state logic: issue, wait for the PHY, then recover before the next chunk.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (phy_done_i) begin
                    if (cfg_rwr_i != 8'd0) begin
                        state_d = RECOVER;
                    end else begin
                        state_d = more_left ? ISSUE : IDLE;
                    end
                end
            end
            RECOVER: begin
                if (rwr_cnt_q <= 8'd1) begin
                    state_d = more_left ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Recovery counter: cfg_rwr_i is sampled only when the PHY reports done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rwr_cnt_q <= 8'd0;
        end else if ((state_q == WAIT_DONE) && phy_done_i) begin
            rwr_cnt_q <= cfg_rwr_i;
        end else if (state_q == RECOVER) begin
            rwr_cnt_q <= rwr_cnt_q - 8'd1;
        end
    end

    // Registered PHY-side outputs. The payload is loaded only on entry to
    // ISSUE, so it stays frozen while the PHY stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trx_valid_o <= 1'b0;
            trx_write_o <= 1'b0;
            trx_addr_o  <= '0;
            trx_len_o   <= '0;
            trx_cs_o    <= '0;
            trx_last_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            trx_valid_o <= (state_d == ISSUE);
            busy_o      <= (state_d != IDLE);
            if (grant_any) begin
                trx_write_o <= grant_wr;
                trx_cs_o    <= NumChips'(1) << req_cs;
            end
            if ((state_d == ISSUE) && (state_q != ISSUE)) begin
                trx_addr_o <= src_addr;
                trx_len_o  <= chunk_len;
                trx_last_o <= chunk_last;
            end
        end
    end

endmodule

// File: tb/tb_hyperbus_trx_sched.sv
// tb_hyperbus_trx_sched: self-checking bench for hyperbus_trx_sched.
// It uses a table of directed requests, a set of randomized requests, and
// hand-written sequences for arbitration and mid-operation reset.
// Expected chunks come from a word-count model that follows
// HYPERBUS_BURST_SPLIT_EN.
module tb_hyperbus_trx_sched;

    localparam int MB = 64;
`ifdef HYPERBUS_BURST_SPLIT_EN
    localparam int SPLIT = 1;
`else
    localparam int SPLIT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        rd_valid_i, rd_ready_o;
    logic [31:0] rd_addr_i;
    logic [15:0] rd_len_i;
    logic        rd_cs_i;
    logic        wr_valid_i, wr_ready_o;
    logic [31:0] wr_addr_i;
    logic [15:0] wr_len_i;
    logic        wr_cs_i;
    logic        trx_valid_o, trx_ready_i, trx_write_o;
    logic [31:0] trx_addr_o;
    logic [15:0] trx_len_o;
    logic [1:0]  trx_cs_o;
    logic        trx_last_o;
    logic        phy_done_i;
    logic [7:0]  cfg_rwr_i;
    logic        busy_o;

    int assertCount = 0;
    int failCount   = 0;
    int hsCount     = 0;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        logic        last;
    } chunk_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [15:0] len;
        logic        cs;
        int          rwr;
        int          rdyDly;
        int          doneDly;
        int          expChunks;
    } vec_t;

    chunk_t expQ[$];
    vec_t   tbl[7];

    hyperbus_trx_sched #(
        .NumChips (2),
        .AddrWidth(32),
        .LenWidth (16),
        .MaxBurst (MB)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rd_valid_i (rd_valid_i),
        .rd_ready_o (rd_ready_o),
        .rd_addr_i  (rd_addr_i),
        .rd_len_i   (rd_len_i),
        .rd_cs_i    (rd_cs_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_addr_i  (wr_addr_i),
        .wr_len_i   (wr_len_i),
        .wr_cs_i    (wr_cs_i),
        .trx_valid_o(trx_valid_o),
        .trx_ready_i(trx_ready_i),
        .trx_write_o(trx_write_o),
        .trx_addr_o (trx_addr_o),
        .trx_len_o  (trx_len_o),
        .trx_cs_o   (trx_cs_o),
        .trx_last_o (trx_last_o),
        .phy_done_i (phy_done_i),
        .cfg_rwr_i  (cfg_rwr_i),
        .busy_o     (busy_o)
    );

    // Free-running clock.
    initial forever #5 clk = ~clk;

    // Count PHY handshakes seen on the bus.
    always @(posedge clk) begin
        if (trx_valid_o && trx_ready_i) hsCount <= hsCount + 1;
    end

    // Build the expected chunk list from the word count alone.
    function automatic void buildModel(input logic [31:0] addr, input logic [15:0] len);
        int          rem;
        int          w;
        logic [31:0] a;
        chunk_t      c;
        expQ.delete();
        rem = int'(len) + 1;
        a   = addr;
        if (SPLIT != 0) begin
            while (rem > 0) begin
                w      = (rem > MB) ? MB : rem;
                c.addr = a;
                c.len  = 16'(w - 1);
                c.last = (rem <= MB);
                expQ.push_back(c);
                a   = a + 32'(w);
                rem = rem - w;
            end
        end else begin
            c.addr = addr;
            c.len  = len;
            c.last = 1'b1;
            expQ.push_back(c);
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkChunk(input logic write, input logic [1:0] csoh, input chunk_t c);
        checkOutput("trx_valid", 64'(trx_valid_o), 64'(1));
        checkOutput("trx_write", 64'(trx_write_o), 64'(write));
        checkOutput("trx_addr",  64'(trx_addr_o),  64'(c.addr));
        checkOutput("trx_len",   64'(trx_len_o),   64'(c.len));
        checkOutput("trx_cs",    64'(trx_cs_o),    64'(csoh));
        checkOutput("trx_last",  64'(trx_last_o),  64'(c.last));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_ready"}, 64'(rd_ready_o),  64'(0));
        checkOutput({tag, "_wr_ready"}, 64'(wr_ready_o),  64'(0));
        checkOutput({tag, "_valid"},    64'(trx_valid_o), 64'(0));
        checkOutput({tag, "_write"},    64'(trx_write_o), 64'(0));
        checkOutput({tag, "_addr"},     64'(trx_addr_o),  64'(0));
        checkOutput({tag, "_len"},      64'(trx_len_o),   64'(0));
        checkOutput({tag, "_cs"},       64'(trx_cs_o),    64'(0));
        checkOutput({tag, "_last"},     64'(trx_last_o),  64'(0));
        checkOutput({tag, "_busy"},     64'(busy_o),      64'(0));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one request from an idle DUT and follow every chunk through
    // ready stall, PHY done and recovery. The task returns in the first
    // cycle where a new grant is allowed.
    task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [15:0] len,
                                 input logic cs, input int rwr, input int rdyDly, input int doneDly,
                                 input int expChunks);
        int         hs0;
        int         nChunks;
        logic [1:0] csoh;
        buildModel(addr, len);
        nChunks = (expChunks < 0) ? expQ.size() : expChunks;
        csoh    = cs ? 2'b10 : 2'b01;
        checkOutput("idle_busy", 64'(busy_o), 64'(0));
        if (write) begin
            wr_valid_i = 1'b1; wr_addr_i = addr; wr_len_i = len; wr_cs_i = cs;
        end else begin
            rd_valid_i = 1'b1; rd_addr_i = addr; rd_len_i = len; rd_cs_i = cs;
        end
        phy_done_i = 1'b1;
        cfg_rwr_i  = 8'(rwr + 3);
        #1;
        checkOutput("grant_rd", 64'(rd_ready_o), 64'(!write));
        checkOutput("grant_wr", 64'(wr_ready_o), 64'(write));
        hs0 = hsCount;
        step;
        rd_valid_i = 1'b0; wr_valid_i = 1'b0; phy_done_i = 1'b0;
        rd_addr_i = $urandom; wr_addr_i = $urandom;
        rd_len_i = 16'($urandom); wr_len_i = 16'($urandom);
        rd_cs_i = ~rd_cs_i; wr_cs_i = ~wr_cs_i;
        for (int c = 0; c < expQ.size(); c++) begin
            for (int d = 0; d < rdyDly; d++) begin
                checkChunk(write, csoh, expQ[c]);
                if (d == 0) phy_done_i = 1'b1;
                step;
                phy_done_i = 1'b0;
            end
            checkChunk(write, csoh, expQ[c]);
            trx_ready_i = 1'b1;
            step;
            trx_ready_i = 1'b0;
            checkOutput("wait_valid", 64'(trx_valid_o), 64'(0));
            checkOutput("wait_busy",  64'(busy_o),      64'(1));
            for (int d = 0; d < doneDly; d++) step;
            phy_done_i = 1'b1;
            cfg_rwr_i  = 8'(rwr);
            step;
            phy_done_i = 1'b0;
            cfg_rwr_i  = 8'(rwr + 3);
            for (int j = 0; j < rwr; j++) begin
                checkOutput("rec_valid", 64'(trx_valid_o), 64'(0));
                checkOutput("rec_busy",  64'(busy_o),      64'(1));
                step;
            end
            if (c < expQ.size() - 1) begin
                checkOutput("reissue_valid", 64'(trx_valid_o), 64'(1));
            end else begin
                checkOutput("end_valid", 64'(trx_valid_o), 64'(0));
                checkOutput("end_busy",  64'(busy_o),      64'(0));
            end
        end
        checkOutput("chunk_count", 64'(hsCount - hs0), 64'(nChunks));
    endtask

    initial begin
        int t;
        rst_i = 1'b1;
        rd_valid_i = 1'b0; rd_addr_i = '0; rd_len_i = '0; rd_cs_i = 1'b0;
        wr_valid_i = 1'b0; wr_addr_i = '0; wr_len_i = '0; wr_cs_i = 1'b0;
        trx_ready_i = 1'b0; phy_done_i = 1'b0; cfg_rwr_i = 8'd0;

        tbl[0] = '{1'b0, 32'h0000_0040, 16'd3,      1'b1, 4, 0,  0, 1};
        tbl[1] = '{1'b1, 32'h0000_0100, 16'd149,    1'b0, 2, 0,  1, SPLIT ? 3 : 1};
        tbl[2] = '{1'b0, 32'h0000_0200, 16'd0,      1'b0, 0, 0,  0, 1};
        tbl[3] = '{1'b1, 32'h0000_0300, 16'd7,      1'b1, 0, 10, 2, 1};
        tbl[4] = '{1'b0, 32'hFFFF_FFF0, 16'd99,     1'b1, 1, 1,  0, SPLIT ? 2 : 1};
        tbl[5] = '{1'b1, 32'h0000_1000, 16'd64,     1'b0, 3, 0,  3, SPLIT ? 2 : 1};
        tbl[6] = '{1'b0, 32'h0000_0000, 16'hFFFF,   1'b0, 0, 0,  0, SPLIT ? 1024 : 1};

        // Reset state, with both requesters already asserting valid.
        rd_valid_i = 1'b1; rd_addr_i = 32'h10; rd_cs_i = 1'b0;
        wr_valid_i = 1'b1; wr_addr_i = 32'h20; wr_cs_i = 1'b1;
        step; step;
        checkAllZero("reset");

        // Arbitration: both channels stay valid, so the grants must alternate starting with read.
        trx_ready_i = 1'b1;
        rst_i = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            t = 0;
            while (!(rd_ready_o || wr_ready_o) && t < 20) begin
                step;
                t++;
            end
            checkOutput("arb_timeout", 64'(t < 20), 64'(1));
            checkOutput("arb_rd_grant", 64'(rd_ready_o), 64'((i % 2) == 0));
            checkOutput("arb_wr_grant", 64'(wr_ready_o), 64'((i % 2) == 1));
            step;
            checkOutput("arb_valid", 64'(trx_valid_o), 64'(1));
            checkOutput("arb_dir",   64'(trx_write_o), 64'((i % 2) == 1));
            step;
            step;
            phy_done_i = 1'b1;
            step;
            phy_done_i = 1'b0;
            #1;
        end
        rd_valid_i = 1'b0; wr_valid_i = 1'b0; trx_ready_i = 1'b0;
        step;

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(tbl[v].write, tbl[v].addr, tbl[v].len, tbl[v].cs,
                          tbl[v].rwr, tbl[v].rdyDly, tbl[v].doneDly, tbl[v].expChunks);
        end

        // Randomized requests.
        for (int r = 0; r < 40; r++) begin
            logic        w, cs;
            logic [31:0] a;
            logic [15:0] l;
            w  = 1'($urandom_range(0, 1));
            cs = 1'($urandom_range(0, 1));
            a  = $urandom;
            l  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom_range(0, 70));
            applyStimulus(w, a, l, cs, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), -1);
        end

        // Reset while waiting for the PHY on a write that would be split.
        wr_valid_i = 1'b1; wr_addr_i = 32'h100; wr_len_i = 16'd149; wr_cs_i = 1'b0;
        cfg_rwr_i = 8'd2;
        #1;
        checkOutput("rst_seq_grant", 64'(wr_ready_o), 64'(1));
        step;
        wr_valid_i = 1'b0;
        checkOutput("rst_seq_valid", 64'(trx_valid_o), 64'(1));
        trx_ready_i = 1'b1;
        step;
        trx_ready_i = 1'b0;
        checkOutput("rst_seq_wait", 64'(busy_o), 64'(1));
        step;
        #2;
        rst_i = 1'b1;
        #1;
        checkAllZero("midrst");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        step;
        checkOutput("post_rst_valid", 64'(trx_valid_o), 64'(0));
        checkOutput("post_rst_busy",  64'(busy_o),      64'(0));
        applyStimulus(1'b0, 32'h0000_0080, 16'd5, 1'b1, 1, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
